// File: rtl/irq_pkg.sv
// Shared definitions for the irq_arbiter interrupt controller:
// line count, FSM state encoding and the priority-encode helpers.
package irq_pkg;

  localparam int NUM_IRQ = 3;
  localparam int LVL_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [LVL_W-1:0] idx;
  } prio_t;

  // Highest set bit of a request vector plus a flag saying any bit was set.
  // Scanning upward lets the highest set bit overwrite lower ones.
  function automatic prio_t prio_enc(input logic [NUM_IRQ-1:0] bits);
    prio_t r;
    r.valid = 1'b0;
    r.idx   = {LVL_W{1'b0}};
    for (int i = 0; i < NUM_IRQ; i++) begin
      r.valid = r.valid | bits[i];
      r.idx   = bits[i] ? LVL_W'(i) : r.idx;
    end
    return r;
  endfunction

  // One-hot mask selecting a single level.
  function automatic logic [NUM_IRQ-1:0] onehot(input logic [LVL_W-1:0] idx);
    logic [NUM_IRQ-1:0] r;
    r = {NUM_IRQ{1'b0}};
    for (int i = 0; i < NUM_IRQ; i++) begin
      r[i] = (LVL_W'(i) == idx);
    end
    return r;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous request line, followed by a
// rising-edge detector. rise is a one-cycle pulse built from flop outputs only.
module irq_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Next values: shift the raw line through the synchroniser and delay line.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Synchroniser and edge-history flops, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/irq_arbiter.sv
// irq_arbiter: three-level priority interrupt controller.
// Synchronises and edge-detects the request lines, latches them as pending,
// issues one request (level + handler vector) at a time and tracks the
// in-service set until the matching eret.
// Optional feature macro: IRQ_NEST_EN (nested interrupts). When undefined a
// level is only eligible while nothing is in service.
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int                     WIDTH      = 32,
  parameter logic [WIDTH-1:0]       VEC_BASE   = WIDTH'(32'h0000_0100),
  parameter logic [WIDTH-1:0]       VEC_STRIDE = WIDTH'(32'h0000_0040)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               int_ack,
  input  logic               eret,
  output logic               int_req,
  output logic [WIDTH-1:0]   int_vec,
  output logic [LVL_W-1:0]   int_level,
  output logic [NUM_IRQ-1:0] irw,
  output logic [NUM_IRQ-1:0] in_service
);

  state_e             state_q, state_d;
  logic               int_req_q, int_req_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [WIDTH-1:0]   vec_q, vec_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] in_service_q, in_service_d;

  logic [NUM_IRQ-1:0] edge_s;
  logic [NUM_IRQ-1:0] ins_post_s;
  logic [NUM_IRQ-1:0] above_s;
  logic [NUM_IRQ-1:0] clr_s;
  prio_t              ins_hi_s;
  prio_t              post_hi_s;
  prio_t              elig_s;

  genvar g;
  generate
    for (g = 0; g < NUM_IRQ; g++) begin : g_sync
      irq_sync_edge u_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (irq_in[g]),
        .rise (edge_s[g])
      );
    end
  endgenerate

  // Apply eret to the in-service set first, then pick the eligible level.
  always_comb begin
    ins_hi_s   = prio_enc(in_service_q);
    ins_post_s = in_service_q;
    if (eret && ins_hi_s.valid) begin
      ins_post_s = in_service_q & ~onehot(ins_hi_s.idx);
    end else begin
      ins_post_s = in_service_q;
    end
    post_hi_s = prio_enc(ins_post_s);
    above_s   = {NUM_IRQ{1'b0}};
`ifdef IRQ_NEST_EN
    // Only levels strictly above every remaining in-service level may preempt.
    for (int i = 0; i < NUM_IRQ; i++) begin
      above_s[i] = !post_hi_s.valid || (LVL_W'(i) > post_hi_s.idx);
    end
`else
    // Without nesting, nothing is eligible while any level is in service.
    above_s = post_hi_s.valid ? {NUM_IRQ{1'b0}} : {NUM_IRQ{1'b1}};
`endif
    elig_s = prio_enc(pending_q & above_s);
  end

  // FSM next state, request latching and pending/in-service bookkeeping.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    vec_d        = vec_q;
    clr_s        = {NUM_IRQ{1'b0}};
    in_service_d = ins_post_s;
    case (state_q)
      IDLE: begin
        if (elig_s.valid) begin
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (int_ack) begin
          state_d      = ACTIVE;
          clr_s        = onehot(level_q);
          in_service_d = ins_post_s | onehot(level_q);
        end else begin
          state_d = REQ;
        end
      end
      ACTIVE: begin
        if (elig_s.valid) begin
          state_d = REQ;
        end else if (ins_post_s == {NUM_IRQ{1'b0}}) begin
          state_d = IDLE;
        end else begin
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Level and vector are frozen on entry to REQ and held until the ack.
    if ((state_q != REQ) && (state_d == REQ)) begin
      level_d = elig_s.idx;
      vec_d   = VEC_BASE + (VEC_STRIDE * WIDTH'(elig_s.idx));
    end else begin
      level_d = level_q;
      vec_d   = vec_q;
    end

    // A fresh edge on the acknowledged line wins over the clear.
    pending_d = (pending_q & ~clr_s) | edge_s;
    int_req_d = (state_d == REQ);
  end

  // Controller state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      int_req_q    <= 1'b0;
      level_q      <= {LVL_W{1'b0}};
      vec_q        <= VEC_BASE;
      pending_q    <= {NUM_IRQ{1'b0}};
      in_service_q <= {NUM_IRQ{1'b0}};
    end else begin
      state_q      <= state_d;
      int_req_q    <= int_req_d;
      level_q      <= level_d;
      vec_q        <= vec_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  assign int_req    = int_req_q;
  assign int_vec    = vec_q;
  assign int_level  = level_q;
  assign irw        = pending_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter. Expected requests (level + vector)
// are queued when lines are raised and compared when int_req is observed.
module tb_irq_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  irq_in;
  logic        int_ack;
  logic        eret;
  logic        int_req;
  logic [31:0] int_vec;
  logic [1:0]  int_level;
  logic [2:0]  irw;
  logic [2:0]  in_service;

  typedef struct {
    logic [1:0]  lvl;
    logic [31:0] vec;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  irq_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .int_ack    (int_ack),
    .eret       (eret),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_level  (int_level),
    .irw        (irw),
    .in_service (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [1:0] lvl);
    exp_t e;
    e.lvl = lvl;
    case (lvl)
      2'd0:    e.vec = 32'h0000_0100;
      2'd1:    e.vec = 32'h0000_0140;
      default: e.vec = 32'h0000_0180;
    endcase
    sb.push_back(e);
  endtask

  // Hold lines high for three cycles, then release them.
  task automatic pulse_lines(input logic [2:0] bits);
    irq_in = bits;
    repeat (3) step();
    irq_in = 3'b000;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    step();
    eret = 1'b0;
  endtask

  // Wait (bounded) for int_req, then compare against the scoreboard head.
  task automatic wait_req(input string name);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (int_req === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: timeout int_req=%b required 1", name, int_req);
    end else if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: unexpected request level=%0d", name, int_level);
    end else begin
      e = sb.pop_front();
      if (int_level !== e.lvl) begin
        bad++;
        $display("FAIL %s level: got %0d required %0d", name, int_level, e.lvl);
      end
      total++;
      if (int_vec !== e.vec) begin
        bad++;
        $display("FAIL %s vec: got %h required %h", name, int_vec, e.vec);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b required 0", int_req); end
    total++; if (int_vec !== 32'h100) begin bad++; $display("FAIL rst_vec: got %h required 100", int_vec); end
    total++; if (int_level !== 2'd0) begin bad++; $display("FAIL rst_level: got %0d required 0", int_level); end
    total++; if (irw !== 3'b000) begin bad++; $display("FAIL rst_irw: got %b required 000", irw); end
    total++; if (in_service !== 3'b000) begin bad++; $display("FAIL rst_ins: got %b required 000", in_service); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_latency();
    irq_in = 3'b001;
    push_exp(2'd0);
    step();  // after edge k
    step();  // after edge k+1
    total++; if (irw !== 3'b000) begin bad++; $display("FAIL lat_irw_k1: got %b required 000", irw); end
    step();  // after edge k+2
    total++; if (irw !== 3'b001) begin bad++; $display("FAIL lat_irw_k2: got %b required 001", irw); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL lat_req_k2: got %b required 0", int_req); end
    irq_in = 3'b000;
    wait_req("lat_req_k3");
    do_ack();
    total++; if (in_service !== 3'b001) begin bad++; $display("FAIL basic_ack_ins: got %b required 001", in_service); end
    total++; if (irw !== 3'b000) begin bad++; $display("FAIL basic_ack_irw: got %b required 000", irw); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL basic_ack_req: got %b required 0", int_req); end
    do_eret();
    total++; if (in_service !== 3'b000) begin bad++; $display("FAIL basic_eret_ins: got %b required 000", in_service); end
    repeat (3) step();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL basic_idle_req: got %b required 0", int_req); end
  endtask

  task automatic test_priority();
    bit spurious;
    push_exp(2'd2);
    pulse_lines(3'b101);
    wait_req("prio_first");
    do_ack();
    total++; if (in_service !== 3'b100) begin bad++; $display("FAIL prio_ins: got %b required 100", in_service); end
    spurious = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (int_req !== 1'b0) spurious = 1'b1;
    end
    total++; if (spurious) begin bad++; $display("FAIL prio_blocked: got req=1 required 0"); end
    total++; if (irw !== 3'b001) begin bad++; $display("FAIL prio_irw_held: got %b required 001", irw); end
    push_exp(2'd0);
    do_eret();
    wait_req("prio_second");
    do_ack();
    do_eret();
    total++; if (in_service !== 3'b000) begin bad++; $display("FAIL prio_end_ins: got %b required 000", in_service); end
  endtask

  task automatic test_nesting();
`ifdef IRQ_NEST_EN
    push_exp(2'd0);
    pulse_lines(3'b001);
    wait_req("nest_l0");
    do_ack();
    push_exp(2'd1);
    pulse_lines(3'b010);
    wait_req("nest_l1");
    do_ack();
    total++; if (in_service !== 3'b011) begin bad++; $display("FAIL nest_ins: got %b required 011", in_service); end
    do_eret();
    total++; if (in_service !== 3'b001) begin bad++; $display("FAIL nest_eret1: got %b required 001", in_service); end
    do_eret();
    total++; if (in_service !== 3'b000) begin bad++; $display("FAIL nest_eret2: got %b required 000", in_service); end
`else
    bit spurious;
    push_exp(2'd0);
    pulse_lines(3'b001);
    wait_req("nonest_l0");
    do_ack();
    pulse_lines(3'b100);
    spurious = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (int_req !== 1'b0) spurious = 1'b1;
    end
    total++; if (spurious) begin bad++; $display("FAIL nonest_blocked: got req=1 required 0"); end
    total++; if (irw !== 3'b100) begin bad++; $display("FAIL nonest_irw: got %b required 100", irw); end
    total++; if (in_service !== 3'b001) begin bad++; $display("FAIL nonest_ins: got %b required 001", in_service); end
    push_exp(2'd2);
    do_eret();
    wait_req("nonest_l2");
    do_ack();
    do_eret();
    total++; if (in_service !== 3'b000) begin bad++; $display("FAIL nonest_end_ins: got %b required 000", in_service); end
`endif
  endtask

  task automatic test_stable_latch();
    bit moved;
    push_exp(2'd0);
    pulse_lines(3'b001);
    wait_req("latch_l0");
    irq_in = 3'b100;
    moved = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (int_level !== 2'd0 || int_vec !== 32'h100 || int_req !== 1'b1) moved = 1'b1;
    end
    irq_in = 3'b000;
    total++; if (moved) begin bad++; $display("FAIL latch_hold: got level=%0d vec=%h required 0/100", int_level, int_vec); end
    push_exp(2'd2);
    do_ack();
    do_eret();
    wait_req("latch_l2");
    do_ack();
    do_eret();
    total++; if (in_service !== 3'b000) begin bad++; $display("FAIL latch_end_ins: got %b required 000", in_service); end
  endtask

  task automatic test_ack_edge();
    push_exp(2'd0);
    pulse_lines(3'b001);
    wait_req("collide_first");
    repeat (3) step();
    irq_in = 3'b001;   // edge pulse lands at the same edge as the ack
    step();
    step();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    irq_in = 3'b000;
    total++; if (in_service !== 3'b001) begin bad++; $display("FAIL collide_ins: got %b required 001", in_service); end
    total++; if (irw !== 3'b001) begin bad++; $display("FAIL collide_irw: got %b required 001", irw); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL collide_req: got %b required 0", int_req); end
    push_exp(2'd0);
    do_eret();
    wait_req("collide_again");
    do_ack();
    do_eret();
  endtask

  task automatic test_eret_idle();
    do_eret();
    total++; if (in_service !== 3'b000) begin bad++; $display("FAIL eret_idle_ins: got %b required 000", in_service); end
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL eret_idle_req: got %b required 0", int_req); end
  endtask

  task automatic test_reset_mid();
    bit reissued;
    push_exp(2'd1);
    pulse_lines(3'b010);
    wait_req("rstmid_req");
    rst = 1'b1;
    #1;
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL rstmid_req: got %b required 0", int_req); end
    total++; if (int_vec !== 32'h100) begin bad++; $display("FAIL rstmid_vec: got %h required 100", int_vec); end
    total++; if (int_level !== 2'd0) begin bad++; $display("FAIL rstmid_level: got %0d required 0", int_level); end
    total++; if (irw !== 3'b000 || in_service !== 3'b000) begin bad++; $display("FAIL rstmid_bits: got irw=%b ins=%b required 000", irw, in_service); end
    step();
    rst = 1'b0;
    reissued = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (int_req !== 1'b0 || irw !== 3'b000) reissued = 1'b1;
    end
    total++; if (reissued) begin bad++; $display("FAIL rstmid_reissue: got req=%b irw=%b required 0/000", int_req, irw); end
    push_exp(2'd1);
    pulse_lines(3'b010);
    wait_req("rstmid_new");
    do_ack();
    do_eret();
  endtask

  initial begin
    rst     = 1'b1;
    irq_in  = 3'b000;
    int_ack = 1'b0;
    eret    = 1'b0;
    test_reset();
    test_basic_latency();
    test_priority();
    test_nesting();
    test_stable_latch();
    test_ack_edge();
    test_eret_idle();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left: got %0d entries required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Three-level priority interrupt controller for the interrupt pipeline CPU. It sits between the board request buttons and the CPU pipeline. It synchronises and edge-detects the three request lines and latches them as pending. It then presents one interrupt request with its handler vector to the pipeline and tracks the in-service set until the matching `eret`. Pending bits drive the `IRW` lamps on the board.

## Interface
Parameters:
- `WIDTH`, 32: width of the vector address, equal to the CPU PC width.
- `VEC_BASE`, 32'h0000_0100: handler address for level 0.
- `VEC_STRIDE`, 32'h0000_0040: address distance between consecutive level handlers.

Ports:
- `clk`  in  1: CPU clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `irq_in`  in  3: raw request lines (BTN[2:0]), asynchronous to `clk`. Bit 2 has the highest priority.
- `int_ack`  in  1: pipeline accepts the current request (one-cycle pulse). Ignored unless `int_req` is high.
- `eret`  in  1: pipeline retires a return-from-interrupt (one-cycle pulse).
- `int_req`  out  1: interrupt request to the pipeline.
- `int_vec`  out  WIDTH: handler address, valid while `int_req` is high.
- `int_level`  out  2: level of the current request, 0..2.
- `irw`  out  3: pending bits, driven to the board lamps.
- `in_service`  out  3: in-service bits.

## Operation
- Per line: two-flop synchroniser, then rising-edge detect. An edge sets `pending[i]`. Further edges while `pending[i]` is set collapse into it.
- Eligible level: the highest set `pending[i]` with `i` greater than the highest set `in_service` bit (or any `i` when `in_service` is 0).
- FSM states and transitions:
  - IDLE: when any level is eligible, go to REQ.
  - REQ: on `int_ack`, set `in_service[level]`, clear `pending[level]`, go to ACTIVE.
  - ACTIVE:
    - On `eret`, clear the highest set `in_service` bit. If `in_service` becomes 0 and nothing is eligible, go to IDLE.
    - When a level is eligible, go to REQ.
    - If both hold in the same cycle, apply `eret` first, then evaluate eligibility.
- Output values: `int_req` is 1 only in REQ. `int_level` and `int_vec = VEC_BASE + int_level*VEC_STRIDE` are latched when REQ is entered and held stable until `int_ack`, even if a higher level becomes pending meanwhile. That higher level is requested after the ack.
- Simultaneous events:
  - Edge on line `i` in the same cycle as `int_ack` for level `i`: `pending[i]` stays set (the new edge is kept) and `in_service[i]` is set.
  - `eret` while in REQ: clears the highest in-service bit. The request already latched is not withdrawn.
  - `eret` with `in_service` = 0: ignored.
- Reset mid-operation clears everything immediately: any outstanding request is dropped, and the pipeline is expected to be reset by the same `rst`.
- Vector arithmetic is WIDTH-bit unsigned; overflow wraps silently.

## Timing
- Reset values: `int_req`=0, `int_vec`=VEC_BASE, `int_level`=0, `irw`=0, `in_service`=0, FSM=IDLE, synchroniser flops=0.
- Request latency: `irq_in[i]` rises before clock edge k. Synchroniser stage 1 captures at k and stage 2 at k+1. `pending[i]` (and `irw[i]`) is set at k+2. `int_req` goes high at k+3.
- Ack: with `int_ack` high at edge m, `int_req` is 0, `in_service` is updated and `pending` is cleared from edge m onward. If another level is eligible, `int_req` can be high again at m+1 at the earliest.
- `eret` takes effect at the edge where it is sampled.
- Minimum high time for a raw pulse to be caught: 2 `clk` periods.

## Configuration
- `IRQ_NEST_EN` defined: nesting as described above. A higher level than every in-service level may be requested while in ACTIVE.
- `IRQ_NEST_EN` not defined: a level is eligible only when `in_service` is 0. `in_service` then holds at most one bit, and new requests wait in `pending` until `eret`.

## Structure
- Package `irq_pkg` holds:
  - the `NUM_IRQ`=3 constant;
  - the FSM state enum (IDLE, REQ, ACTIVE);
  - the priority-encode function returning the highest set bit and a valid flag.
- Sub-module `irq_sync_edge` (two-flop synchroniser plus rising-edge pulse), instantiated once per line.

## Test plan
- After reset, raise `irq_in`=3'b001 before edge k: `irw`=001 at k+2, `int_req`=1 at k+3 with `int_vec`=32'h100 and `int_level`=0. Pulse `int_ack`: `in_service`=001, `irw`=000. Pulse `eret`: `in_service`=000, FSM returns to IDLE.
- Raise lines 0 and 2 in the same cycle: first request has `int_vec`=32'h180 (level 2). After ack and `eret`, the level-0 request follows with vector 32'h100.
- Nesting on: service level 0, then raise line 1. `int_req` rises with vector 32'h140; after ack `in_service`=011. Two `eret`s clear bit 1 first, then bit 0.
- Nesting on: service level 2, then raise line 0. No request is issued until `eret`; `irw`=001 is held throughout.
- Nesting off: service level 0, then raise line 2. No request until `eret`, then vector 32'h180.
- Raise line 1 and assert `rst` while `int_req`=1: all outputs return to reset values asynchronously. The request is not reissued after reset unless a new edge occurs.
